// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks an address range of a 1-cycle-latency block RAM and
// streams the returned words on a valid/ready interface through a 2-entry buffer.
module bram_stream_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0]    rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state, state_next;
    logic [ADDRESS_WIDTH:0] to_issue, to_send;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic [1:0] count;
    logic rd_ptr, wr_ptr, inflight, pop, issue;
    assign out_valid = count != 2'd0;
    assign out_data = fifo[rd_ptr];
    assign out_last = out_valid && to_send == (ADDRESS_WIDTH+1)'(1);
    assign pop = out_valid && out_ready;
    // raddr doubles as the address counter, so the RAM already sees the next address when issue fires
    assign issue = state == RUN && to_issue != '0 &&
                   ({1'b0, count} + {2'b0, inflight} <= {2'b0, pop} + 3'd1);
    always_comb begin
        busy = state == RUN;
        done = state == FINISH;
        state_next = state == IDLE ? (start ? (length == '0 ? FINISH : RUN) : IDLE) :
                     state == RUN  ? (pop && out_last ? FINISH : RUN) : IDLE;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            raddr    <= '0;
            to_issue <= '0;
            to_send  <= '0;
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (state == IDLE && start && length != '0) begin
                raddr    <= base_addr;
                to_issue <= length;
                to_send  <= length;
            end
            if (issue) begin
                raddr    <= raddr + 1'b1;
                to_issue <= to_issue - 1'b1;
            end
            if (inflight) begin
                fifo[wr_ptr] <= rdata;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                to_send <= to_send - 1'b1;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(inflight && count == 2'd2 && !pop));
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed stimulus against a write-first RAM model; a negedge
// monitor pops hand-computed expected beats from a scoreboard queue.
module tb_bram_stream_reader;
    localparam int DW = 16;
    localparam int AW = 11;
    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0] length = '0;
    logic busy, done, out_valid, out_last;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata, out_data;
    logic [DW-1:0] mem [2**AW];
    logic we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW:0] exp_q [$];
    int total = 0, bad = 0, nbeats = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clock = ~clock;

    // write-first RAM with registered read port
    always @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic issue_cmd(input int b, input int n);
        base_addr = AW'(b);
        length = (AW+1)'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic finish_cmd(input int limit, input bit toggle);
        int dn = 0;
        for (int k = 0; k < limit && dn == 0; k++) begin
            if (toggle) out_ready = (k % 5 == 0) || (k % 5 == 3);
            if (done) dn++;
            tick;
        end
        out_ready = 1'b1;
        chk("done_seen", dn, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    always @(negedge clock) begin
        logic [DW:0] e;
        if (!reset_n) prev_stall = 1'b0;
        else begin
            if (prev_stall) chk("stall_stable", {out_valid, out_data}, {1'b1, prev_data});
            if (out_valid && out_ready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("data", out_data, e[DW-1:0]);
                    chk("last", out_last, e[DW]);
                end
                nbeats++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i + 'h100);
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_raddr", raddr, 0);
        reset_n = 1'b1;
        tick;
        // base 5, length 4, no backpressure: beats in cycles 3..6, done in 7
        out_ready = 1'b1;
        push(16'h105, 0); push(16'h106, 0); push(16'h107, 0); push(16'h108, 1);
        issue_cmd(5, 4);
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("t1_busy_c%0d", k), busy, k <= 6);
            chk($sformatf("t1_valid_c%0d", k), out_valid, k >= 3 && k <= 6);
            chk($sformatf("t1_done_c%0d", k), done, k == 7);
            if (k == 1) chk("t1_raddr_c1", raddr, 5);
            tick;
        end
        chk("t1_done_c8", done, 0);
        chk("t1_queue", exp_q.size(), 0);
        // address wrap
        push(16'h8FE, 0); push(16'h8FF, 0); push(16'h100, 0); push(16'h101, 1);
        issue_cmd(2046, 4);
        finish_cmd(20, 0);
        // backpressure pattern 1,0,0,1,0
        for (int i = 0; i < 8; i++) push(DW'(16'h114 + i), i == 7);
        issue_cmd(20, 8);
        finish_cmd(100, 1);
        // zero length
        issue_cmd(0, 0);
        chk("z_done_c1", done, 1);
        chk("z_busy_c1", busy, 0);
        chk("z_valid_c1", out_valid, 0);
        tick;
        chk("z_done_c2", done, 0);
        chk("z_busy_c2", busy, 0);
        chk("z_valid_c2", out_valid, 0);
        // reset after 3 beats of a length-10 command
        nbeats = 0;
        for (int i = 0; i < 10; i++) push(DW'(16'h128 + i), i == 9);
        issue_cmd(40, 10);
        for (int k = 0; k < 5; k++) tick;
        reset_n = 1'b0;
        #1;
        chk("mr_beats", nbeats, 3);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_last", out_last, 0);
        chk("mr_raddr", raddr, 0);
        chk("mr_data", out_data, 0);
        exp_q.delete();
        tick;
        chk("mr_no_done", done, 0);
        reset_n = 1'b1;
        tick;
        chk("mr_idle_done", done, 0);
        push(16'h100, 0); push(16'h101, 1);
        issue_cmd(0, 2);
        finish_cmd(20, 0);
        // write collision on address 7 plus an ignored start while busy
        push(16'h106, 0); push(16'hBEEF, 0); push(16'h108, 1);
        issue_cmd(6, 3);
        chk("col_raddr_c1", raddr, 6);
        base_addr = AW'(100);
        length = (AW+1)'(5);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("col_raddr_c2", raddr, 7);
        we = 1'b1;
        waddr = AW'(7);
        wdata = 16'hBEEF;
        tick;
        we = 1'b0;
        begin
            int dn = 0;
            for (int k = 0; k < 12; k++) begin
                if (done) dn++;
                tick;
            end
            chk("col_done_count", dn, 1);
        end
        chk("col_queue", exp_q.size(), 0);
        chk("col_idle_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side sequencer placed directly upstream of the 1-cycle-latency block RAM (registered read port, no read enable, write-first forwarding on address collision). On a start command it walks a contiguous address range, drives the RAM read address, captures each returned word in the only cycle it is valid, and presents the words on a valid/ready stream with backpressure and a last-beat marker. A 2-entry output buffer absorbs the RAM latency so the stream sustains one word per cycle when the consumer never stalls.

## Interface
- DATA_WIDTH, 16, word width; must match the RAM.
- ADDRESS_WIDTH, 11, RAM address width; address space is 2^ADDRESS_WIDTH words.
- clock  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe, sampled only while idle.
- base_addr  in  ADDRESS_WIDTH  first address of the range, sampled with start.
- length  in  ADDRESS_WIDTH+1  number of words (0..2^ADDRESS_WIDTH), sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a command completes.
- raddr  out  ADDRESS_WIDTH  RAM read address, registered.
- rdata  in  DATA_WIDTH  RAM read data; valid in the cycle after an issue only.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready; a beat transfers when out_valid && out_ready.
- out_data  out  DATA_WIDTH  stream word; holds stable while out_valid && !out_ready.
- out_last  out  1  marks the final word of the command.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: start=1 latches base_addr and length. If length=0, go to FINISH. Otherwise load the address counter with base_addr and the remaining-to-issue and remaining-to-send counters with length, then go to RUN. Start while busy is ignored.
- RUN, issue rule:
  - Credits = 2 - buffer_count - inflight + pop, where pop = out_valid && out_ready and inflight is a 1-bit flag for "issued last cycle".
  - Issue when the remaining-to-issue count is nonzero and credits >= 1.
  - An issue presents raddr for that cycle, sets inflight for the next cycle, increments the address, and decrements remaining-to-issue.
- Address arithmetic is modulo 2^ADDRESS_WIDTH: the address after 2^ADDRESS_WIDTH-1 is 0. length = 2^ADDRESS_WIDTH reads every word exactly once.
- Capture: in every cycle where inflight=1, rdata is written into the 2-entry FIFO. The rdata value in any other cycle is ignored. By construction the FIFO never overflows; an overflow is a design error and is asserted against in simulation.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_last = 1 when the head is the final word (remaining-to-send = 1).
  - Each transfer decrements remaining-to-send.
- The transfer with out_last moves the FSM to FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE. A start arriving in FINISH is ignored.
- Write collisions: if the RAM is written at the issued address in the issue cycle, the streamed word is the new data (write-first). This block adds no forwarding of its own.
- Reset values (async, reset_n=0): IDLE, busy=0, done=0, out_valid=0, out_last=0, raddr=0, inflight=0, FIFO empty, counters 0. Reset mid-command abandons the command with no done pulse. The next command after release behaves normally.

## Timing
- Cycle 0: start accepted. Cycle 1: busy=1, first issue (raddr=base). Cycle 2: rdata valid, captured. Cycle 3: first out_valid.
- With out_ready held at 1, one beat per cycle: N words occupy out_valid in cycles 3..N+2. done pulses in cycle N+3, and busy is low from cycle N+3.
- length=0: done in cycle 1, busy never asserted, no beats.
- Stall: with out_ready=0, at most 2 words are buffered and issue stops. After out_ready rises, beats resume with no bubble and no word is lost or duplicated.
- raddr holds its last value when not issuing. The RAM ignores it because the reader discards the corresponding rdata.

## Test plan
- Preload RAM[i]=i+0x100. start, base=5, length=4, out_ready=1 -> beats 0x105,0x106,0x107,0x108 in cycles 3-6, out_last only on 0x108, done in cycle 7.
- base=2046, length=4, ADDRESS_WIDTH=11 -> addresses 2046,2047,0,1 are streamed in order.
- length=8, out_ready toggles 1,0,0,1,0 repeating -> all 8 words are delivered in order, out_data is stable during stalls, and inflight+buffer never exceeds 2.
- length=0 -> done in cycle 1, out_valid stays 0, busy stays 0.
- Assert reset_n=0 after 3 beats of a length-10 command -> all outputs are 0 immediately. After release, a new command (base=0, length=2) streams RAM[0], RAM[1] normally.
- Write RAM[7]=0xBEEF in the same cycle that raddr=7 is issued -> the streamed word is 0xBEEF. A second start during busy is ignored (exactly one done pulse).
